// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: burst/response encodings, channel field widths
// and a constant-foldable clog2 used to size pointers and counters.
package axi_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_RESP_W  = 2;

    typedef enum logic [AXI_BURST_W-1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [AXI_RESP_W-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_sync_fwft.sv
// Single-clock first-word-fall-through FIFO; full/empty derive from a
// registered occupancy counter, so a same-cycle pop never frees a push slot.
module fifo_sync_fwft
    import axi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            din_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            dout_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [axi_pkg::clog2(DEPTH):0] count_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are only observable while counted.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/axi_wr_fifo_pkt.sv
// AXI4 write-path buffer: AW and W FIFOs with optional packet mode that
// releases an address only once its whole burst is held in the W FIFO.
module axi_wr_fifo_pkt
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH = 32,
    parameter int AW_DEPTH   = 4,
    parameter int FIFO_DELAY = 0
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [ID_WIDTH-1:0]    s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
    input  logic [AXI_LEN_W-1:0]   s_axi_awlen,
    input  logic [AXI_SIZE_W-1:0]  s_axi_awsize,
    input  logic [AXI_BURST_W-1:0] s_axi_awburst,
    input  logic [AXI_CACHE_W-1:0] s_axi_awcache,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,

    input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]  s_axi_wstrb,
    input  logic                   s_axi_wlast,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,

    output logic [ID_WIDTH-1:0]    s_axi_bid,
    output logic [AXI_RESP_W-1:0]  s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,

    output logic [ID_WIDTH-1:0]    m_axi_awid,
    output logic [ADDR_WIDTH-1:0]  m_axi_awaddr,
    output logic [AXI_LEN_W-1:0]   m_axi_awlen,
    output logic [AXI_SIZE_W-1:0]  m_axi_awsize,
    output logic [AXI_BURST_W-1:0] m_axi_awburst,
    output logic [AXI_CACHE_W-1:0] m_axi_awcache,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,

    output logic [DATA_WIDTH-1:0]  m_axi_wdata,
    output logic [STRB_WIDTH-1:0]  m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,

    input  logic [ID_WIDTH-1:0]    m_axi_bid,
    input  logic [AXI_RESP_W-1:0]  m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready
);

    localparam int AW_W     = ID_WIDTH + ADDR_WIDTH + AXI_LEN_W + AXI_SIZE_W
                              + AXI_BURST_W + AXI_CACHE_W;
    localparam int W_W      = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int CMPL_W   = clog2(FIFO_DEPTH) + 1;
    localparam int AW_CNT_W = clog2(AW_DEPTH) + 1;
    localparam int W_CNT_W  = clog2(FIFO_DEPTH) + 1;
    localparam logic [CMPL_W-1:0] CMPL_ONE = 1;

    logic [AW_W-1:0]     aw_din, aw_dout;
    logic [W_W-1:0]      w_din, w_dout;
    logic                aw_full, aw_empty, w_full, w_empty;
    logic [AW_CNT_W-1:0] aw_count;
    logic [W_CNT_W-1:0]  w_count;
    logic                aw_push, aw_pop, w_push, w_pop;
    logic                cmpl_inc, cmpl_dec;
    logic [CMPL_W-1:0]   cmpl_cnt_q, cmpl_cnt_d;
    logic                unused_cnt;

    assign aw_din = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
                     s_axi_awburst, s_axi_awcache};
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
            m_axi_awburst, m_axi_awcache} = aw_dout;
    assign w_din = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_dout;

    assign s_axi_awready = !aw_full;
    assign s_axi_wready  = !w_full;
    assign m_axi_wvalid  = !w_empty;
    assign m_axi_awvalid = !aw_empty && ((FIFO_DELAY == 0) || (cmpl_cnt_q != '0));

    assign aw_push = s_axi_awvalid && s_axi_awready;
    assign aw_pop  = m_axi_awvalid && m_axi_awready;
    assign w_push  = s_axi_wvalid && s_axi_wready;
    assign w_pop   = m_axi_wvalid && m_axi_wready;

    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;

    assign unused_cnt = ^{aw_count, w_count};

    fifo_sync_fwft #(
        .WIDTH (AW_W),
        .DEPTH (AW_DEPTH)
    ) u_aw_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (aw_push),
        .din_i   (aw_din),
        .pop_i   (aw_pop),
        .dout_o  (aw_dout),
        .full_o  (aw_full),
        .empty_o (aw_empty),
        .count_o (aw_count)
    );

    fifo_sync_fwft #(
        .WIDTH (W_W),
        .DEPTH (FIFO_DEPTH)
    ) u_w_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (w_push),
        .din_i   (w_din),
        .pop_i   (w_pop),
        .dout_o  (w_dout),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Completed bursts waiting for their address; held at zero in cut-through.
    assign cmpl_inc = (FIFO_DELAY != 0) && w_push && s_axi_wlast;
    assign cmpl_dec = aw_pop && (cmpl_cnt_q != '0);

    always_comb begin
        cmpl_cnt_d = cmpl_cnt_q;
        case ({cmpl_inc, cmpl_dec})
            2'b10:   cmpl_cnt_d = cmpl_cnt_q + CMPL_ONE;
            2'b01:   cmpl_cnt_d = cmpl_cnt_q - CMPL_ONE;
            default: cmpl_cnt_d = cmpl_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmpl_cnt_q <= '0;
        end else begin
            cmpl_cnt_q <= cmpl_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_fifo_pkt.sv
// Drives a cut-through and a packet-mode instance side by side and checks
// both against queue-based models of the AW/W buffers and burst release rule.
module tb_axi_wr_fifo_pkt;

    localparam int DW  = 32;
    localparam int AWD = 32;
    localparam int IDW = 8;
    localparam int SW  = DW / 8;
    localparam int FD  = 32;
    localparam int AD  = 4;
    localparam int AWT = IDW + AWD + 8 + 3 + 2 + 4;
    localparam int WT  = DW + SW + 1;
    localparam int NB  = 60;

    typedef logic [AWT-1:0] aw_t;
    typedef logic [WT-1:0]  w_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aw_t  awpay_c, awpay_p;
    logic awvalid_c, awvalid_p;
    w_t   wpay;
    logic wvalid;
    logic m_awready, m_wready, s_bready;
    logic [IDW-1:0] m_bid;
    logic [1:0]     m_bresp;
    logic           m_bvalid;

    logic awready_c, wready_c, mawvalid_c, mwvalid_c, sbvalid_c, mbready_c;
    logic awready_p, wready_p, mawvalid_p, mwvalid_p, sbvalid_p, mbready_p;
    aw_t  maw_c, maw_p;
    w_t   mw_c, mw_p;
    logic [IDW-1:0] sbid_c, sbid_p;
    logic [1:0]     sbresp_c, sbresp_p;

    axi_wr_fifo_pkt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .ID_WIDTH(IDW),
                      .FIFO_DEPTH(FD), .AW_DEPTH(AD), .FIFO_DELAY(0)) dut_c (
        .clk(clk), .rst(rst),
        .s_axi_awid(awpay_c[56:49]), .s_axi_awaddr(awpay_c[48:17]),
        .s_axi_awlen(awpay_c[16:9]), .s_axi_awsize(awpay_c[8:6]),
        .s_axi_awburst(awpay_c[5:4]), .s_axi_awcache(awpay_c[3:0]),
        .s_axi_awvalid(awvalid_c), .s_axi_awready(awready_c),
        .s_axi_wdata(wpay[36:5]), .s_axi_wstrb(wpay[4:1]), .s_axi_wlast(wpay[0]),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready_c),
        .s_axi_bid(sbid_c), .s_axi_bresp(sbresp_c), .s_axi_bvalid(sbvalid_c),
        .s_axi_bready(s_bready),
        .m_axi_awid(maw_c[56:49]), .m_axi_awaddr(maw_c[48:17]),
        .m_axi_awlen(maw_c[16:9]), .m_axi_awsize(maw_c[8:6]),
        .m_axi_awburst(maw_c[5:4]), .m_axi_awcache(maw_c[3:0]),
        .m_axi_awvalid(mawvalid_c), .m_axi_awready(m_awready),
        .m_axi_wdata(mw_c[36:5]), .m_axi_wstrb(mw_c[4:1]), .m_axi_wlast(mw_c[0]),
        .m_axi_wvalid(mwvalid_c), .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid),
        .m_axi_bready(mbready_c)
    );

    axi_wr_fifo_pkt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .ID_WIDTH(IDW),
                      .FIFO_DEPTH(FD), .AW_DEPTH(AD), .FIFO_DELAY(1)) dut_p (
        .clk(clk), .rst(rst),
        .s_axi_awid(awpay_p[56:49]), .s_axi_awaddr(awpay_p[48:17]),
        .s_axi_awlen(awpay_p[16:9]), .s_axi_awsize(awpay_p[8:6]),
        .s_axi_awburst(awpay_p[5:4]), .s_axi_awcache(awpay_p[3:0]),
        .s_axi_awvalid(awvalid_p), .s_axi_awready(awready_p),
        .s_axi_wdata(wpay[36:5]), .s_axi_wstrb(wpay[4:1]), .s_axi_wlast(wpay[0]),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready_p),
        .s_axi_bid(sbid_p), .s_axi_bresp(sbresp_p), .s_axi_bvalid(sbvalid_p),
        .s_axi_bready(s_bready),
        .m_axi_awid(maw_p[56:49]), .m_axi_awaddr(maw_p[48:17]),
        .m_axi_awlen(maw_p[16:9]), .m_axi_awsize(maw_p[8:6]),
        .m_axi_awburst(maw_p[5:4]), .m_axi_awcache(maw_p[3:0]),
        .m_axi_awvalid(mawvalid_p), .m_axi_awready(m_awready),
        .m_axi_wdata(mw_p[36:5]), .m_axi_wstrb(mw_p[4:1]), .m_axi_wlast(mw_p[0]),
        .m_axi_wvalid(mwvalid_p), .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid),
        .m_axi_bready(mbready_p)
    );

    // Reference state: buffered entries per FIFO and bursts awaiting release.
    aw_t awq_c[$];
    aw_t awq_p[$];
    w_t  wq[$];
    int  cmpl;
    bit  acc_aw_c, acc_aw_p, acc_w;
    int  n_chk = 0;
    int  n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic aw_t mk_aw(input logic [7:0] id, input logic [31:0] addr,
                                  input logic [7:0] len);
        return {id, addr, len, 3'd2, 2'b01, 4'd3};
    endfunction

    task automatic check_outputs();
        bit exp_awv_p;
        exp_awv_p = (awq_p.size() != 0) && (cmpl > 0);
        check_eq("awready_c", 64'(awready_c), 64'(awq_c.size() < AD));
        check_eq("awready_p", 64'(awready_p), 64'(awq_p.size() < AD));
        check_eq("wready_c", 64'(wready_c), 64'(wq.size() < FD));
        check_eq("wready_p", 64'(wready_p), 64'(wq.size() < FD));
        check_eq("awvalid_c", 64'(mawvalid_c), 64'(awq_c.size() != 0));
        check_eq("awvalid_p", 64'(mawvalid_p), 64'(exp_awv_p));
        check_eq("wvalid_c", 64'(mwvalid_c), 64'(wq.size() != 0));
        check_eq("wvalid_p", 64'(mwvalid_p), 64'(wq.size() != 0));
        if (awq_c.size() != 0) check_eq("awpay_c", 64'(maw_c), 64'(awq_c[0]));
        if (awq_p.size() != 0) check_eq("awpay_p", 64'(maw_p), 64'(awq_p[0]));
        if (wq.size() != 0) begin
            check_eq("wpay_c", 64'(mw_c), 64'(wq[0]));
            check_eq("wpay_p", 64'(mw_p), 64'(wq[0]));
        end
        check_eq("cmpl_cnt", 64'(dut_p.cmpl_cnt_q), 64'(cmpl));
        check_eq("b_pass_c", 64'({sbid_c, sbresp_c, sbvalid_c, mbready_c}),
                 64'({m_bid, m_bresp, m_bvalid, s_bready}));
        check_eq("b_pass_p", 64'({sbid_p, sbresp_p, sbvalid_p, mbready_p}),
                 64'({m_bid, m_bresp, m_bvalid, s_bready}));
    endtask

    // One clock: predict handshakes from pre-edge state, advance the model, check.
    task automatic cycle();
        bit in_c, in_p, out_c, out_p, w_in, w_out;
        in_c  = awvalid_c && (awq_c.size() < AD);
        in_p  = awvalid_p && (awq_p.size() < AD);
        out_c = (awq_c.size() != 0) && m_awready;
        out_p = (awq_p.size() != 0) && (cmpl > 0) && m_awready;
        w_in  = wvalid && (wq.size() < FD);
        w_out = (wq.size() != 0) && m_wready;
        @(posedge clk);
        if (out_c) awq_c.delete(0);
        if (out_p) awq_p.delete(0);
        if (w_out) wq.delete(0);
        if (in_c) awq_c.push_back(awpay_c);
        if (in_p) awq_p.push_back(awpay_p);
        if (w_in) wq.push_back(wpay);
        cmpl = cmpl + ((w_in && wpay[0]) ? 1 : 0) - (out_p ? 1 : 0);
        acc_aw_c = in_c;
        acc_aw_p = in_p;
        acc_w    = w_in;
        #1;
        check_outputs();
    endtask

    task automatic aw_both(input aw_t v);
        awpay_c = v; awpay_p = v;
        awvalid_c = 1'b1; awvalid_p = 1'b1;
    endtask

    task automatic model_clear();
        awq_c.delete(); awq_p.delete(); wq.delete();
        cmpl = 0;
    endtask

    aw_t aw_list[NB];
    int  lens[NB];
    int  ai_c, ai_p, wb, bt, nacc, thr;
    bit  done;
    logic [DW-1:0] rd;

    initial begin
        rst = 1'b1;
        awpay_c = '0; awpay_p = '0; awvalid_c = 1'b0; awvalid_p = 1'b0;
        wpay = '0; wvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; s_bready = 1'b0;
        m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        check_eq("rst_awready", 64'(awready_c), 64'd1);
        check_eq("rst_wvalid", 64'(mwvalid_p), 64'd0);

        // Cut-through single beat with B pass-through
        m_awready = 1'b1; m_wready = 1'b1; s_bready = 1'b1;
        m_bid = 8'h05; m_bresp = 2'd0; m_bvalid = 1'b1;
        aw_both(mk_aw(8'h05, 32'h1000, 8'd0));
        cycle();
        check_eq("ct_aw_lat", 64'(mawvalid_c), 64'd1);
        check_eq("ct_aw_id", 64'(maw_c[56:49]), 64'h05);
        awvalid_c = 1'b0; awvalid_p = 1'b0;
        wpay = {32'hDEADBEEF, 4'hF, 1'b1}; wvalid = 1'b1;
        cycle();
        check_eq("ct_w_data", 64'(mw_c), 64'({32'hDEADBEEF, 4'hF, 1'b1}));
        check_eq("ct_bid", 64'(sbid_c), 64'h05);
        wvalid = 1'b0;
        repeat (2) cycle();

        // Packet mode: AW first, then 4 beats with idle gaps
        aw_both(mk_aw(8'h11, 32'h2000, 8'd3));
        cycle();
        awvalid_c = 1'b0; awvalid_p = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wpay = {32'hA0000000 + 32'(b), 4'hF, b == 3}; wvalid = 1'b1;
            cycle();
            if (b < 3) check_eq("pk_aw_held", 64'(mawvalid_p), 64'd0);
            else       check_eq("pk_aw_rel", 64'(mawvalid_p), 64'd1);
            wvalid = 1'b0;
            cycle();
        end
        repeat (2) cycle();

        // Packet mode: two bursts buffered before their addresses
        wpay = {32'hB0, 4'h3, 1'b0}; wvalid = 1'b1; cycle();
        wpay = {32'hB1, 4'hC, 1'b1}; cycle();
        wpay = {32'hB2, 4'hF, 1'b1}; cycle();
        wvalid = 1'b0;
        check_eq("pk_cmpl2", 64'(dut_p.cmpl_cnt_q), 64'd2);
        aw_both(mk_aw(8'h21, 32'h3000, 8'd1)); cycle();
        check_eq("pk_q_first", 64'(mawvalid_p), 64'd1);
        aw_both(mk_aw(8'h22, 32'h3100, 8'd0)); cycle();
        check_eq("pk_cmpl1", 64'(dut_p.cmpl_cnt_q), 64'd1);
        awvalid_c = 1'b0; awvalid_p = 1'b0;
        cycle();
        check_eq("pk_cmpl0", 64'(dut_p.cmpl_cnt_q), 64'd0);
        cycle();
        // Simultaneous wlast push and AW pop
        m_awready = 1'b0;
        aw_both(mk_aw(8'h23, 32'h3200, 8'd0)); cycle();
        aw_both(mk_aw(8'h24, 32'h3300, 8'd0)); cycle();
        awvalid_c = 1'b0; awvalid_p = 1'b0;
        wpay = {32'hC3, 4'hF, 1'b1}; wvalid = 1'b1; cycle();
        wvalid = 1'b0; cycle();
        m_awready = 1'b1;
        wpay = {32'hC4, 4'hF, 1'b1}; wvalid = 1'b1; cycle();
        check_eq("pk_cmpl_same", 64'(dut_p.cmpl_cnt_q), 64'd1);
        wvalid = 1'b0;
        repeat (3) cycle();

        // W FIFO full boundary, then sustained pop+push at the full level
        m_wready = 1'b0; wvalid = 1'b1; nacc = 0;
        wpay = {$urandom(), 4'hF, 1'b0};
        for (int i = 0; i < FD + 1; i++) begin
            cycle();
            if (acc_w) begin nacc++; wpay = {$urandom(), 4'hF, 1'b0}; end
        end
        check_eq("full_accepts", 64'(nacc), 64'(FD));
        check_eq("full_wready", 64'(wready_c), 64'd0);
        m_wready = 1'b1; nacc = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (acc_w) begin nacc++; wpay = {$urandom(), 4'($urandom()), 1'b0}; end
        end
        check_eq("sustain_push", 64'(nacc), 64'd39);
        check_eq("sustain_wready", 64'(wready_p), 64'd1);
        wvalid = 1'b0;
        for (int i = 0; i < FD + 4 && wq.size() != 0; i++) cycle();
        check_eq("full_drained", 64'(wq.size()), 64'd0);

        // Reset in the middle of a burst
        m_awready = 1'b0; m_wready = 1'b0;
        aw_both(mk_aw(8'h31, 32'h4000, 8'd3)); cycle();
        awvalid_c = 1'b0; awvalid_p = 1'b0;
        wpay = {32'hD0, 4'hF, 1'b0}; wvalid = 1'b1; cycle();
        wpay = {32'hD1, 4'hF, 1'b0}; cycle();
        wvalid = 1'b0;
        check_eq("pre_rst_awv", 64'(mawvalid_c), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_async_awv", 64'(mawvalid_c), 64'd0);
        check_eq("rst_async_wv", 64'(mwvalid_c), 64'd0);
        check_eq("rst_async_cmpl", 64'(dut_p.cmpl_cnt_q), 64'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        m_awready = 1'b1; m_wready = 1'b1;
        aw_both(mk_aw(8'h32, 32'h5000, 8'd3)); cycle();
        awvalid_c = 1'b0; awvalid_p = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wpay = {32'hE0 + 32'(b), 4'hF, b == 3}; wvalid = 1'b1; cycle();
        end
        wvalid = 1'b0;
        repeat (4) cycle();

        // Randomised traffic with independent AW/W streams
        for (int i = 0; i < NB; i++) begin
            lens[i] = $urandom_range(0, 7);
            aw_list[i] = mk_aw(8'($urandom()), $urandom(), 8'(lens[i]));
        end
        ai_c = 0; ai_p = 0; wb = 0; bt = 0; done = 1'b0;
        for (int t = 0; t < 8000 && !done; t++) begin
            case ((t / 200) % 3)
                0:       thr = 90;
                1:       thr = 50;
                default: thr = 15;
            endcase
            if (!awvalid_c && ai_c < NB && $urandom_range(0, 3) != 0) begin
                awvalid_c = 1'b1; awpay_c = aw_list[ai_c];
            end
            if (!awvalid_p && ai_p < NB && $urandom_range(0, 3) != 0) begin
                awvalid_p = 1'b1; awpay_p = aw_list[ai_p];
            end
            if (!wvalid && wb < NB && wb < ai_p + 8 && $urandom_range(0, 3) != 0) begin
                rd = $urandom();
                wvalid = 1'b1; wpay = {rd, 4'($urandom()), bt == lens[wb]};
            end
            m_awready = ($urandom_range(0, 99) < thr);
            m_wready  = ($urandom_range(0, 99) < thr);
            s_bready  = 1'($urandom());
            m_bid = 8'($urandom()); m_bresp = 2'($urandom()); m_bvalid = 1'($urandom());
            cycle();
            if (acc_aw_c) begin awvalid_c = 1'b0; ai_c++; end
            if (acc_aw_p) begin awvalid_p = 1'b0; ai_p++; end
            if (acc_w) begin
                wvalid = 1'b0;
                if (bt == lens[wb]) begin bt = 0; wb++; end
                else bt++;
            end
            done = (ai_c == NB) && (ai_p == NB) && (wb == NB) && (awq_c.size() == 0)
                   && (awq_p.size() == 0) && (wq.size() == 0);
        end
        check_eq("random_drain", 64'(done), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
